// File: rtl/riscv_mem_req_arbiter.sv
// Round-robin arbiter between instruction-fetch and load/store ports in front of the AXI driver,
// with an in-order tag FIFO that steers responses back. Optional perf counters: RISCV_ARB_PERF_EN.
module riscv_mem_req_arbiter #(
    parameter int DEPTH = 16,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        if_req_vld,
    input  logic [31:0] if_req_addr,
    output logic        if_req_ack,
    output logic        if_rsp_vld,
    output logic [31:0] if_rsp_data,

    input  logic        ls_req_vld,
    input  logic        ls_req_rnw,
    input  logic [31:0] ls_req_addr,
    input  logic [31:0] ls_req_data,
    output logic        ls_req_ack,
    output logic        ls_rsp_vld,
    output logic [31:0] ls_rsp_data,

    output logic        req_vld,
    output logic        req_rnw,
    output logic [31:0] req_addr,
    output logic [31:0] req_data,
    input  logic        req_ack,
    input  logic        rsp_vld,
    input  logic [31:0] rsp_data,

    output logic        rsp_orphan,
    output logic [31:0] perf_if_grants,
    output logic [31:0] perf_ls_grants,
    output logic [31:0] perf_stall_cycles
);

    localparam int   CNT_W   = PTR_W + 1;
    localparam logic SRC_IF  = 1'b0;
    localparam logic SRC_LS  = 1'b1;

    logic             last_grant_q, last_grant_d;
    logic [DEPTH-1:0] tag_q, tag_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             rsp_orphan_q, rsp_orphan_d;

    logic full;
    logic empty;
    logic sel_ls;
    logic sel_vld;
    logic accept;
    logic pop;
    logic head_tag;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

    // Tie goes to the port that did not win the last accepted grant.
    assign sel_ls  = ls_req_vld & (~if_req_vld | (last_grant_q == SRC_IF));
    assign sel_vld = sel_ls ? ls_req_vld : if_req_vld;

    assign req_vld  = sel_vld & ~full & ~reset;
    assign req_rnw  = sel_ls ? ls_req_rnw  : 1'b1;
    assign req_addr = sel_ls ? ls_req_addr : if_req_addr;
    assign req_data = sel_ls ? ls_req_data : 32'd0;

    assign accept     = req_vld & req_ack;
    assign if_req_ack = accept & ~sel_ls;
    assign ls_req_ack = accept & sel_ls;

    assign head_tag    = tag_q[rd_ptr_q];
    assign pop         = rsp_vld & ~empty & ~reset;
    assign if_rsp_vld  = pop & (head_tag == SRC_IF);
    assign ls_rsp_vld  = pop & (head_tag == SRC_LS);
    assign if_rsp_data = rsp_data;
    assign ls_rsp_data = rsp_data;
    assign rsp_orphan  = rsp_orphan_q;

    always_comb begin
        last_grant_d = last_grant_q;
        tag_d        = tag_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        rsp_orphan_d = rsp_orphan_q;

        if (accept) begin
            last_grant_d    = sel_ls;
            tag_d[wr_ptr_q] = sel_ls;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        if (rsp_vld && empty) begin
            rsp_orphan_d = 1'b1;
        end

        case ({accept, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_grant_q <= SRC_LS;
            tag_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            rsp_orphan_q <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            tag_q        <= tag_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            rsp_orphan_q <= rsp_orphan_d;
        end
    end

`ifdef RISCV_ARB_PERF_EN
    logic [31:0] perf_if_q, perf_if_d;
    logic [31:0] perf_ls_q, perf_ls_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_if_d    = perf_if_q;
        perf_ls_d    = perf_ls_q;
        perf_stall_d = perf_stall_q;
        if (if_req_ack) begin
            perf_if_d = perf_if_q + 32'd1;
        end
        if (ls_req_ack) begin
            perf_ls_d = perf_ls_q + 32'd1;
        end
        if ((if_req_vld | ls_req_vld) & ~accept) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_if_q    <= '0;
            perf_ls_q    <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_if_q    <= perf_if_d;
            perf_ls_q    <= perf_ls_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_if_grants    = perf_if_q;
    assign perf_ls_grants    = perf_ls_q;
    assign perf_stall_cycles = perf_stall_q;
`else
    assign perf_if_grants    = 32'd0;
    assign perf_ls_grants    = 32'd0;
    assign perf_stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_riscv_mem_req_arbiter.sv
// Directed bench for riscv_mem_req_arbiter: queue-based reference model checked every cycle,
// plus literal expectations taken from the test plan.
module tb_riscv_mem_req_arbiter;

    localparam int DEPTH = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic        if_req_vld;
    logic [31:0] if_req_addr;
    logic        if_req_ack;
    logic        if_rsp_vld;
    logic [31:0] if_rsp_data;
    logic        ls_req_vld;
    logic        ls_req_rnw;
    logic [31:0] ls_req_addr;
    logic [31:0] ls_req_data;
    logic        ls_req_ack;
    logic        ls_rsp_vld;
    logic [31:0] ls_rsp_data;
    logic        req_vld;
    logic        req_rnw;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic        req_ack;
    logic        rsp_vld;
    logic [31:0] rsp_data;
    logic        rsp_orphan;
    logic [31:0] perf_if_grants;
    logic [31:0] perf_ls_grants;
    logic [31:0] perf_stall_cycles;

    int errors = 0;
    int checks = 0;

    riscv_mem_req_arbiter #(.DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .if_req_vld(if_req_vld), .if_req_addr(if_req_addr), .if_req_ack(if_req_ack),
        .if_rsp_vld(if_rsp_vld), .if_rsp_data(if_rsp_data),
        .ls_req_vld(ls_req_vld), .ls_req_rnw(ls_req_rnw), .ls_req_addr(ls_req_addr),
        .ls_req_data(ls_req_data), .ls_req_ack(ls_req_ack),
        .ls_rsp_vld(ls_rsp_vld), .ls_rsp_data(ls_rsp_data),
        .req_vld(req_vld), .req_rnw(req_rnw), .req_addr(req_addr), .req_data(req_data),
        .req_ack(req_ack), .rsp_vld(rsp_vld), .rsp_data(rsp_data),
        .rsp_orphan(rsp_orphan),
        .perf_if_grants(perf_if_grants), .perf_ls_grants(perf_ls_grants),
        .perf_stall_cycles(perf_stall_cycles)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: outstanding sources in issue order (0=IF, 1=LS).
    bit          m_q[$];
    bit          m_last_ls = 1'b1;
    bit          m_orphan  = 1'b0;
    int unsigned m_pif = 0, m_pls = 0, m_pst = 0;
    bit          m_pick_ls, m_vld, m_acc, m_head;

    always @(negedge clock) begin
        if (reset) begin
            chk("rst_req_vld", 32'(req_vld), 0);
            chk("rst_if_ack", 32'(if_req_ack), 0);
            chk("rst_ls_ack", 32'(ls_req_ack), 0);
            chk("rst_if_rsp", 32'(if_rsp_vld), 0);
            chk("rst_ls_rsp", 32'(ls_rsp_vld), 0);
            chk("rst_orphan", 32'(rsp_orphan), 0);
            m_q.delete();
            m_last_ls = 1'b1;
            m_orphan  = 1'b0;
            m_pif = 0; m_pls = 0; m_pst = 0;
        end else begin
            m_pick_ls = ls_req_vld && (!if_req_vld || !m_last_ls);
            m_vld     = (if_req_vld || ls_req_vld) && (m_q.size() < DEPTH);
            m_acc     = m_vld && req_ack;
            chk("m_req_vld", 32'(req_vld), 32'(m_vld));
            chk("m_if_ack", 32'(if_req_ack), 32'(m_acc && !m_pick_ls));
            chk("m_ls_ack", 32'(ls_req_ack), 32'(m_acc && m_pick_ls));
            if (m_vld) begin
                chk("m_req_addr", req_addr, m_pick_ls ? ls_req_addr : if_req_addr);
                chk("m_req_rnw", 32'(req_rnw), m_pick_ls ? 32'(ls_req_rnw) : 32'd1);
                chk("m_req_data", req_data, m_pick_ls ? ls_req_data : 32'd0);
            end
            if (rsp_vld && m_q.size() > 0) begin
                m_head = m_q[0];
                chk("m_if_rsp", 32'(if_rsp_vld), 32'(!m_head));
                chk("m_ls_rsp", 32'(ls_rsp_vld), 32'(m_head));
                chk("m_rsp_data", m_head ? ls_rsp_data : if_rsp_data, rsp_data);
            end else begin
                chk("m_if_rsp_idle", 32'(if_rsp_vld), 0);
                chk("m_ls_rsp_idle", 32'(ls_rsp_vld), 0);
            end
            chk("m_orphan", 32'(rsp_orphan), 32'(m_orphan));
`ifdef RISCV_ARB_PERF_EN
            chk("m_perf_if", perf_if_grants, m_pif);
            chk("m_perf_ls", perf_ls_grants, m_pls);
            chk("m_perf_stall", perf_stall_cycles, m_pst);
`else
            chk("m_perf_if", perf_if_grants, 0);
            chk("m_perf_ls", perf_ls_grants, 0);
            chk("m_perf_stall", perf_stall_cycles, 0);
`endif
            // state after the coming edge; inputs stay stable until then
            if (rsp_vld) begin
                if (m_q.size() > 0) void'(m_q.pop_front());
                else m_orphan = 1'b1;
            end
            if (m_acc) begin
                m_q.push_back(m_pick_ls);
                m_last_ls = m_pick_ls;
                if (m_pick_ls) m_pls++; else m_pif++;
            end
            if ((if_req_vld || ls_req_vld) && !m_acc) m_pst++;
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        if_req_vld = 0; if_req_addr = 0;
        ls_req_vld = 0; ls_req_rnw = 1; ls_req_addr = 0; ls_req_data = 0;
        req_ack = 0; rsp_vld = 0; rsp_data = 0;
    endtask

    task automatic do_reset();
        step(); idle(); reset = 1;
        step(); reset = 0;
    endtask

    bit exp_ls_pat [4] = '{0, 1, 0, 1};

    initial begin
        reset = 1;
        idle();
        step(); step();
        chk("reset_req_vld", 32'(req_vld), 0);
        chk("reset_orphan", 32'(rsp_orphan), 0);
        chk("reset_perf_if", perf_if_grants, 0);
        reset = 0;

        // IF read then its response
        step(); if_req_vld = 1; if_req_addr = 32'h100; req_ack = 1; #1;
        chk("if_req_vld", 32'(req_vld), 1);
        chk("if_req_rnw", 32'(req_rnw), 1);
        chk("if_req_addr", req_addr, 32'h100);
        chk("if_req_ack", 32'(if_req_ack), 1);
        step(); idle();
        step(); rsp_vld = 1; rsp_data = 32'hDEADBEEF; #1;
        chk("if_rsp_vld", 32'(if_rsp_vld), 1);
        chk("if_rsp_data", if_rsp_data, 32'hDEADBEEF);
        chk("if_rsp_ls_quiet", 32'(ls_rsp_vld), 0);
        step(); idle();

        // round robin from reset
        do_reset();
        if_req_vld = 1; if_req_addr = 32'h1000;
        ls_req_vld = 1; ls_req_rnw = 1; ls_req_addr = 32'h3000; req_ack = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_ls_ack", 32'(ls_req_ack), 32'(exp_ls_pat[i]));
            chk("rr_if_ack", 32'(if_req_ack), 32'(!exp_ls_pat[i]));
            step();
        end
        idle();
        for (int i = 0; i < 4; i++) begin
            rsp_vld = 1; rsp_data = 32'hA0 + 32'(i); #1;
            chk("rr_rsp_ls", 32'(ls_rsp_vld), 32'(exp_ls_pat[i]));
            chk("rr_rsp_if", 32'(if_rsp_vld), 32'(!exp_ls_pat[i]));
            step();
        end
        idle();

        // LS store
        step(); ls_req_vld = 1; ls_req_rnw = 0; ls_req_addr = 32'h2000; ls_req_data = 32'h55AA; req_ack = 1; #1;
        chk("st_rnw", 32'(req_rnw), 0);
        chk("st_data", req_data, 32'h55AA);
        chk("st_ack", 32'(ls_req_ack), 1);
        step(); idle();
        step(); rsp_vld = 1; rsp_data = 32'h1; #1;
        chk("st_rsp_ls", 32'(ls_rsp_vld), 1);
        chk("st_rsp_if", 32'(if_rsp_vld), 0);
        step(); idle();

        // fill to DEPTH, no bypass, then push+pop at count 8
        if_req_vld = 1; req_ack = 1;
        for (int i = 0; i < DEPTH; i++) begin
            if_req_addr = 32'h4000 + 32'(i * 4); #1;
            chk("fill_ack", 32'(if_req_ack), 1);
            step();
        end
        #1;
        chk("full_req_vld", 32'(req_vld), 0);
        chk("full_ack", 32'(if_req_ack), 0);
        step(); rsp_vld = 1; rsp_data = 32'h77; #1;
        chk("nobypass_ack", 32'(if_req_ack), 0);
        chk("nobypass_pop", 32'(if_rsp_vld), 1);
        step(); rsp_vld = 0; #1;
        chk("after_pop_ack", 32'(if_req_ack), 1);
        step(); if_req_vld = 0;
        for (int i = 0; i < 8; i++) begin
            rsp_vld = 1; rsp_data = 32'(i);
            step();
        end
        if_req_vld = 1; rsp_vld = 1; #1;
        chk("pushpop_ack", 32'(if_req_ack), 1);
        chk("pushpop_rsp", 32'(if_rsp_vld), 1);
        step(); rsp_vld = 0;
        for (int i = 0; i < 8; i++) begin
            #1; chk("refill_ack", 32'(if_req_ack), 1);
            step();
        end
        #1;
        chk("refill_full", 32'(req_vld), 0);
        step(); if_req_vld = 0; req_ack = 0;
        for (int i = 0; i < DEPTH; i++) begin
            rsp_vld = 1; rsp_data = 32'h900 + 32'(i);
            step();
        end
        idle();

        // orphan response, then async reset with 5 outstanding
        step(); rsp_vld = 1; rsp_data = 32'hBAD; #1;
        chk("orph_if_rsp", 32'(if_rsp_vld), 0);
        chk("orph_ls_rsp", 32'(ls_rsp_vld), 0);
        step(); idle(); #1;
        chk("orph_set", 32'(rsp_orphan), 1);
        step(); step(); #1;
        chk("orph_sticky", 32'(rsp_orphan), 1);
        step(); if_req_vld = 1; if_req_addr = 32'h8000; req_ack = 1;
        for (int i = 0; i < 5; i++) step();
        rsp_vld = 1; reset = 1; #1;
        chk("arst_req_vld", 32'(req_vld), 0);
        chk("arst_if_ack", 32'(if_req_ack), 0);
        chk("arst_if_rsp", 32'(if_rsp_vld), 0);
        chk("arst_orphan", 32'(rsp_orphan), 0);
        step(); idle(); reset = 0;
        step(); rsp_vld = 1; #1;
        chk("arst_empty_rsp", 32'(if_rsp_vld), 0);
        step(); idle(); #1;
        chk("arst_orphan_again", 32'(rsp_orphan), 1);

        // perf counters: 3 IF, 2 LS, 4 refused
        do_reset();
        if_req_vld = 1; if_req_addr = 32'hC0; req_ack = 1;
        step(); step(); step();
        if_req_vld = 0; ls_req_vld = 1; ls_req_rnw = 0; ls_req_addr = 32'hD0;
        step(); step();
        ls_req_vld = 0; if_req_vld = 1; req_ack = 0;
        step(); step(); step(); step();
        idle(); #1;
`ifdef RISCV_ARB_PERF_EN
        chk("perf_if", perf_if_grants, 3);
        chk("perf_ls", perf_ls_grants, 2);
        chk("perf_stall", perf_stall_cycles, 4);
`else
        chk("perf_if_off", perf_if_grants, 0);
        chk("perf_ls_off", perf_ls_grants, 0);
        chk("perf_stall_off", perf_stall_cycles, 0);
`endif
        step(); step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
